// File: rtl/wb_cfg_arbiter.sv
// Two-master Wishbone arbiter in front of a single configuration slave.
// Grants alternate on ties, every grant is followed by at least one idle
// turnaround cycle, and a stalled slave is cut off after TIMEOUT cycles.
module wb_cfg_arbiter #(
    parameter int         DATA_WIDTH = 16,
    parameter int         ADDR_WIDTH = 15,
    parameter logic [7:0] TIMEOUT    = 8'd15
) (
    input  logic                    clk,
    input  logic                    resetn,
    input  logic [1:0]              m_cyc_i,
    input  logic [1:0]              m_stb_i,
    input  logic [1:0]              m_we_i,
    input  logic [2*ADDR_WIDTH-1:0] m_adr_i,
    input  logic [2*DATA_WIDTH-1:0] m_dat_i,
    input  logic [3:0]              m_sel_i,
    output logic [DATA_WIDTH-1:0]   m_dat_o,
    output logic [1:0]              m_ack_o,
    output logic [1:0]              m_err_o,
    output logic                    s_cyc_o,
    output logic                    s_stb_o,
    output logic                    s_we_o,
    output logic [ADDR_WIDTH-1:0]   s_adr_o,
    output logic [DATA_WIDTH-1:0]   s_dat_o,
    output logic [1:0]              s_sel_o,
    input  logic [DATA_WIDTH-1:0]   s_dat_i,
    input  logic                    s_ack_i,
    output logic [1:0]              grant_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    // Counter value on the last cycle a grant may last without an ack.
    localparam logic [7:0] TO_LAST = TIMEOUT - 8'd1;

    state_t          state_reg, state_next;
    logic            last_served_reg, last_served_next;
    logic [7:0]      cnt_reg, cnt_next;
    logic [1:0]      req;
    logic            idx;
    logic            timeout_hit;

    logic [ADDR_WIDTH-1:0] adr_arr [2];
    logic [DATA_WIDTH-1:0] dat_arr [2];
    logic [1:0]            sel_arr [2];

    // Unpack the per-master buses so the grant mux can index them directly.
    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_master
            assign req[gi]     = m_cyc_i[gi] & m_stb_i[gi];
            assign adr_arr[gi] = m_adr_i[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign dat_arr[gi] = m_dat_i[gi*DATA_WIDTH +: DATA_WIDTH];
            assign sel_arr[gi] = m_sel_i[2*gi +: 2];
        end
    endgenerate

    // State, fairness bit and stall counter; reset aborts any transfer.
    always_ff @(posedge clk) begin
        if (resetn) begin
            state_reg       <= IDLE;
            last_served_reg <= 1'b1;
            cnt_reg         <= 8'd0;
        end else begin
            state_reg       <= state_next;
            last_served_reg <= last_served_next;
            cnt_reg         <= cnt_next;
        end
    end

    // Arbitration, bus mux, ack/err routing and release conditions.
    always_comb begin
        state_next       = state_reg;
        last_served_next = last_served_reg;
        cnt_next         = cnt_reg;
        idx              = 1'b0;
        timeout_hit      = 1'b0;
        grant_o          = 2'b00;
        m_ack_o          = 2'b00;
        m_err_o          = 2'b00;
        m_dat_o          = s_dat_i;
        s_cyc_o          = 1'b0;
        s_stb_o          = 1'b0;
        s_we_o           = 1'b0;
        s_adr_o          = '0;
        s_dat_o          = '0;
        s_sel_o          = 2'b00;

        case (state_reg)
            IDLE: begin
                cnt_next = 8'd0;
                if (req == 2'b11) begin
                    // Tie: the master that was not served last goes first.
                    if (last_served_reg) begin
                        state_next       = GNT0;
                        last_served_next = 1'b0;
                    end else begin
                        state_next       = GNT1;
                        last_served_next = 1'b1;
                    end
                end else if (req[0]) begin
                    state_next       = GNT0;
                    last_served_next = 1'b0;
                end else if (req[1]) begin
                    state_next       = GNT1;
                    last_served_next = 1'b1;
                end
            end

            GNT0, GNT1: begin
                idx          = (state_reg == GNT1);
                grant_o[idx] = 1'b1;
                s_cyc_o      = m_cyc_i[idx];
                s_stb_o      = m_stb_i[idx];
                s_we_o       = m_we_i[idx];
                s_adr_o      = adr_arr[idx];
                s_dat_o      = dat_arr[idx];
                s_sel_o      = sel_arr[idx];
                m_ack_o[idx] = s_ack_i;
                // An ack in the final allowed cycle still completes normally.
                timeout_hit  = (cnt_reg == TO_LAST) & ~s_ack_i;
                // A master that already dropped cyc gets no error pulse.
                m_err_o[idx] = timeout_hit & m_cyc_i[idx];
                if (s_ack_i | ~m_cyc_i[idx] | timeout_hit) begin
                    state_next = IDLE;
                    cnt_next   = 8'd0;
                end else begin
                    cnt_next   = cnt_reg + 8'd1;
                end
            end

            default: begin
                state_next = IDLE;
                cnt_next   = 8'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_wb_cfg_arbiter.sv
// Bench for wb_cfg_arbiter: directed vector table for the documented
// scenarios, then randomized traffic checked every cycle against a
// transaction-level model (owner / cycles-waited / last winner).
module tb_wb_cfg_arbiter;

    localparam int         DW         = 16;
    localparam int         AW         = 15;
    localparam int         TB_TIMEOUT = 4;
    localparam int         NVEC       = 35;

    logic            clk = 1'b0;
    logic            resetn = 1'b1;
    logic [1:0]      m_cyc_i = 2'b00;
    logic [1:0]      m_stb_i = 2'b00;
    logic [1:0]      m_we_i = 2'b00;
    logic [2*AW-1:0] m_adr_i = '0;
    logic [2*DW-1:0] m_dat_i = '0;
    logic [3:0]      m_sel_i = 4'b0000;
    logic [DW-1:0]   m_dat_o;
    logic [1:0]      m_ack_o;
    logic [1:0]      m_err_o;
    logic            s_cyc_o, s_stb_o, s_we_o;
    logic [AW-1:0]   s_adr_o;
    logic [DW-1:0]   s_dat_o;
    logic [1:0]      s_sel_o;
    logic [DW-1:0]   s_dat_i = '0;
    logic            s_ack_i = 1'b0;
    logic [1:0]      grant_o;

    int checks = 0;
    int failures = 0;
    bit model_en = 1'b0;

    wb_cfg_arbiter #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW),
        .TIMEOUT(8'(TB_TIMEOUT))
    ) dut (
        .clk(clk), .resetn(resetn),
        .m_cyc_i(m_cyc_i), .m_stb_i(m_stb_i), .m_we_i(m_we_i),
        .m_adr_i(m_adr_i), .m_dat_i(m_dat_i), .m_sel_i(m_sel_i),
        .m_dat_o(m_dat_o), .m_ack_o(m_ack_o), .m_err_o(m_err_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o),
        .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o),
        .s_dat_i(s_dat_i), .s_ack_i(s_ack_i), .grant_o(grant_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // owner: -1 = nobody holds the bus; waited: granted cycles already spent.
    int m_owner = -1;
    int m_last = 1;
    int m_waited = 0;
    wire [1:0] req = m_cyc_i & m_stb_i;

    always @(posedge clk) begin
        if (resetn) begin
            m_owner  <= -1;
            m_last   <= 1;
            m_waited <= 0;
        end else if (m_owner < 0) begin
            m_waited <= 0;
            if (req == 2'b11) begin
                m_owner <= 1 - m_last;
                m_last  <= 1 - m_last;
            end else if (req[0]) begin
                m_owner <= 0;
                m_last  <= 0;
            end else if (req[1]) begin
                m_owner <= 1;
                m_last  <= 1;
            end
        end else begin
            m_waited <= m_waited + 1;
            if (s_ack_i || !m_cyc_i[m_owner] || (m_waited + 1 == TB_TIMEOUT)) begin
                m_owner <= -1;
                if (model_en && (s_ack_i || m_cyc_i[m_owner]))
                    $display("txn master=%0d %s cycles=%0d", m_owner,
                             s_ack_i ? "ack" : "timeout", m_waited + 1);
            end
        end
    end

    task automatic check_model();
        logic [1:0]  e_gnt = 2'b00;
        logic [1:0]  e_ack = 2'b00;
        logic [1:0]  e_err = 2'b00;
        logic [35:0] e_bus = '0;
        int o = m_owner;
        if (o >= 0) begin
            e_gnt[o] = 1'b1;
            e_ack[o] = s_ack_i;
            e_err[o] = !s_ack_i && m_cyc_i[o] && (m_waited + 1 == TB_TIMEOUT);
            e_bus    = {m_cyc_i[o], m_stb_i[o], m_we_i[o], m_adr_i[o*AW +: AW],
                        m_dat_i[o*DW +: DW], m_sel_i[2*o +: 2]};
        end
        check("model_grant", 64'(grant_o), 64'(e_gnt));
        check("model_ack",   64'(m_ack_o), 64'(e_ack));
        check("model_err",   64'(m_err_o), 64'(e_err));
        check("model_sbus",  64'({s_cyc_o, s_stb_o, s_we_o, s_adr_o, s_dat_o, s_sel_o}), 64'(e_bus));
        check("model_mdat",  64'(m_dat_o), 64'(s_dat_i));
    endtask

    always @(negedge clk) if (model_en) check_model();

    // ---------------- directed vector table ----------------
    typedef struct {
        logic          rst;
        logic [1:0]    cyc;
        logic [1:0]    we;
        logic          ack;
        logic [1:0]    e_gnt;
        logic [1:0]    e_ack;
        logic [1:0]    e_err;
        logic          e_scyc;
        logic          e_swe;
        logic [AW-1:0] e_sadr;
    } vec_t;

    vec_t vecs [NVEC];

    function automatic vec_t mk(input logic rst, input logic [1:0] cyc, input logic [1:0] we,
                                input logic ack, input logic [1:0] e_gnt, input logic [1:0] e_ack,
                                input logic [1:0] e_err, input logic e_scyc, input logic e_swe,
                                input logic [AW-1:0] e_sadr);
        vec_t v;
        v.rst = rst; v.cyc = cyc; v.we = we; v.ack = ack;
        v.e_gnt = e_gnt; v.e_ack = e_ack; v.e_err = e_err;
        v.e_scyc = e_scyc; v.e_swe = e_swe; v.e_sadr = e_sadr;
        return v;
    endfunction

    initial begin
        // reset state, including requests held during reset
        vecs[0]  = mk(1, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 15'h0);
        vecs[1]  = mk(1, 2'b11, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 15'h0);
        // m0 read of 0x0006, slave acks one cycle after stb
        vecs[2]  = mk(0, 2'b01, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 15'h0);
        vecs[3]  = mk(0, 2'b01, 2'b00, 0, 2'b01, 2'b00, 2'b00, 1, 0, 15'h6);
        vecs[4]  = mk(0, 2'b01, 2'b00, 1, 2'b01, 2'b01, 2'b00, 1, 0, 15'h6);
        vecs[5]  = mk(0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 15'h0);
        // m1 write 0x1234 to 0x0007
        vecs[6]  = mk(0, 2'b10, 2'b10, 0, 2'b00, 2'b00, 2'b00, 0, 0, 15'h0);
        vecs[7]  = mk(0, 2'b10, 2'b10, 0, 2'b10, 2'b00, 2'b00, 1, 1, 15'h7);
        vecs[8]  = mk(0, 2'b10, 2'b10, 1, 2'b10, 2'b10, 2'b00, 1, 1, 15'h7);
        vecs[9]  = mk(0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 15'h0);
        // m0 with a silent slave: error on the 4th granted cycle
        vecs[10] = mk(0, 2'b01, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 15'h0);
        vecs[11] = mk(0, 2'b01, 2'b00, 0, 2'b01, 2'b00, 2'b00, 1, 0, 15'h6);
        vecs[12] = mk(0, 2'b01, 2'b00, 0, 2'b01, 2'b00, 2'b00, 1, 0, 15'h6);
        vecs[13] = mk(0, 2'b01, 2'b00, 0, 2'b01, 2'b00, 2'b00, 1, 0, 15'h6);
        vecs[14] = mk(0, 2'b01, 2'b00, 0, 2'b01, 2'b00, 2'b01, 1, 0, 15'h6);
        vecs[15] = mk(0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 15'h0);
        // ack lands on the timeout cycle: ack wins
        vecs[16] = mk(0, 2'b01, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 15'h0);
        vecs[17] = mk(0, 2'b01, 2'b00, 0, 2'b01, 2'b00, 2'b00, 1, 0, 15'h6);
        vecs[18] = mk(0, 2'b01, 2'b00, 0, 2'b01, 2'b00, 2'b00, 1, 0, 15'h6);
        vecs[19] = mk(0, 2'b01, 2'b00, 0, 2'b01, 2'b00, 2'b00, 1, 0, 15'h6);
        vecs[20] = mk(0, 2'b01, 2'b00, 1, 2'b01, 2'b01, 2'b00, 1, 0, 15'h6);
        vecs[21] = mk(0, 2'b00, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 15'h0);
        // both request from reset: 01,00,10,00,01
        vecs[22] = mk(1, 2'b11, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 15'h0);
        vecs[23] = mk(0, 2'b11, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 15'h0);
        vecs[24] = mk(0, 2'b11, 2'b00, 1, 2'b01, 2'b01, 2'b00, 1, 0, 15'h6);
        vecs[25] = mk(0, 2'b11, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 15'h0);
        vecs[26] = mk(0, 2'b11, 2'b00, 1, 2'b10, 2'b10, 2'b00, 1, 0, 15'h7);
        vecs[27] = mk(0, 2'b11, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 15'h0);
        vecs[28] = mk(0, 2'b11, 2'b00, 1, 2'b01, 2'b01, 2'b00, 1, 0, 15'h6);
        vecs[29] = mk(0, 2'b11, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 15'h0);
        // reset during GNT1, then the next tie goes to master 0
        vecs[30] = mk(1, 2'b11, 2'b00, 0, 2'b10, 2'b00, 2'b00, 1, 0, 15'h7);
        vecs[31] = mk(0, 2'b11, 2'b00, 0, 2'b00, 2'b00, 2'b00, 0, 0, 15'h0);
        vecs[32] = mk(0, 2'b11, 2'b00, 0, 2'b01, 2'b00, 2'b00, 1, 0, 15'h6);
        // m0 drops cyc mid-grant: bus mirrors it, no ack/err, then idle
        vecs[33] = mk(0, 2'b00, 2'b00, 0, 2'b01, 2'b00, 2'b00, 0, 0, 15'h6);
        // slave ack while idle is ignored
        vecs[34] = mk(0, 2'b00, 2'b00, 1, 2'b00, 2'b00, 2'b00, 0, 0, 15'h0);

        m_adr_i = {15'h0007, 15'h0006};
        m_dat_i = {16'h1234, 16'h5678};
        m_sel_i = 4'b1101;
        s_dat_i = 16'hBEEF;

        @(posedge clk);
        model_en = 1'b1;

        for (int i = 0; i < NVEC; i++) begin
            #1;
            resetn  = vecs[i].rst;
            m_cyc_i = vecs[i].cyc;
            m_stb_i = vecs[i].cyc;
            m_we_i  = vecs[i].we;
            s_ack_i = vecs[i].ack;
            @(negedge clk);
            $display("row %0d rst=%b cyc=%b ack=%b -> gnt=%b mack=%b err=%b scyc=%b sadr=%h",
                     i, resetn, m_cyc_i, s_ack_i, grant_o, m_ack_o, m_err_o, s_cyc_o, s_adr_o);
            check($sformatf("r%0d_grant", i), 64'(grant_o), 64'(vecs[i].e_gnt));
            check($sformatf("r%0d_ack", i),   64'(m_ack_o), 64'(vecs[i].e_ack));
            check($sformatf("r%0d_err", i),   64'(m_err_o), 64'(vecs[i].e_err));
            check($sformatf("r%0d_scyc", i),  64'({s_cyc_o, s_stb_o}), 64'({vecs[i].e_scyc, vecs[i].e_scyc}));
            check($sformatf("r%0d_swe", i),   64'(s_we_o), 64'(vecs[i].e_swe));
            check($sformatf("r%0d_sadr", i),  64'(s_adr_o), 64'(vecs[i].e_sadr));
            if (vecs[i].e_swe)
                check($sformatf("r%0d_sdat", i), 64'(s_dat_o), 64'(16'h1234));
            check($sformatf("r%0d_mdat", i), 64'(m_dat_o), 64'(16'hBEEF));
            @(posedge clk);
        end

        // ---------------- randomized traffic ----------------
        for (int c = 0; c < 1200; c++) begin
            #1;
            resetn     = ($urandom_range(0, 99) == 0);
            m_cyc_i[0] = ($urandom_range(0, 3) != 0);
            m_cyc_i[1] = ($urandom_range(0, 3) != 0);
            m_stb_i    = m_cyc_i & {($urandom_range(0, 9) != 0), ($urandom_range(0, 9) != 0)};
            m_we_i     = 2'($urandom);
            m_adr_i    = (2*AW)'($urandom);
            m_dat_i    = (2*DW)'($urandom);
            m_sel_i    = 4'($urandom);
            s_dat_i    = DW'($urandom);
            s_ack_i    = ($urandom_range(0, 3) == 0);
            @(posedge clk);
        end

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
